// File: rtl/mode_speed_pkg.sv
// ---------------------------------------------------------------------------
// mode_speed_pkg
// Shared definitions for the push-button mode/speed front end:
//   - select width and count for the display mode and speed selects
//   - default debounce and long-press durations (50 MHz clock)
//   - key indices used to address the per-key debouncer instances
//   - sel_t, the 2-bit select type carried on mode / sw
//   - sel_next(), modulo-4 increment used for each press
// ---------------------------------------------------------------------------
package mode_speed_pkg;

    localparam int SEL_W     = 2;
    localparam int SEL_COUNT = 4;

    // 20 ms and 2 s at 50 MHz
    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int LONG_CYCLES_DEF     = 100_000_000;

    localparam int NUM_KEYS  = 2;
    localparam int KEY_MODE  = 0;
    localparam int KEY_SPEED = 1;

    typedef logic [SEL_W-1:0] sel_t;

    // Step a select to its next value, wrapping 3 -> 0.
    function automatic sel_t sel_next(input sel_t s);
        return sel_t'((int'(s) + 1) % SEL_COUNT);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// One raw board key -> 2-FF synchronizer -> debounce counter -> clean level.
// Ports:
//   clk      in  system clock
//   rst      in  synchronous active-high reset
//   btn_raw  in  raw asynchronous key level
//   db       out debounced level, 1 = pressed (registered)
//   press    out single-cycle strobe, high on the edge where db goes
//                released -> pressed (combinational, aligned with db_d so the
//                consumer can register its reaction on that same edge)
// DEBOUNCE_CYCLES must be >= 2.
// ---------------------------------------------------------------------------
module btn_debounce
    import mode_speed_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic db,
    output logic press
);

    localparam int               CNT_W        = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic             RELEASED_RAW = BTN_ACTIVE_LOW ? 1'b1 : 1'b0;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_pressed;

    // Synchronized level translated to "1 = pressed" regardless of polarity.
    assign level_pressed = (sync2_q != RELEASED_RAW);

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = cnt_q;
        press   = 1'b0;
        if (level_pressed == db_q) begin
            // Any agreement restarts the window, so short glitches vanish.
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            db_d  = ~db_q;
            cnt_d = '0;
            press = ~db_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Start from the released level so reset never looks like a press.
            sync1_q <= RELEASED_RAW;
            sync2_q <= RELEASED_RAW;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign db = db_q;

endmodule

// File: rtl/mode_speed_ctrl.sv
// ---------------------------------------------------------------------------
// mode_speed_ctrl
// Push-button front end for the 4-mode LED display. Two raw keys are
// debounced; each clean press steps the mode or speed select (mod 4) and
// raises the matching one-cycle change pulse. All outputs are registered.
//
// Ports:
//   clk_50     in  50 MHz system clock
//   rst        in  synchronous active-high reset
//   btn_mode   in  raw asynchronous mode key
//   btn_speed  in  raw asynchronous speed key
//   mode       out display mode select 0..3
//   sw         out speed select 0..3
//   mode_chg   out one-cycle pulse when mode is updated
//   speed_chg  out one-cycle pulse when sw is updated
//
// Optional feature, macro MODE_SPEED_LONG_PRESS_EN:
//   holding the debounced mode key for LONG_CYCLES cycles clears both
//   selects once per hold and pulses both change outputs. Without the macro
//   there is no hold counter and LONG_CYCLES is ignored.
// ---------------------------------------------------------------------------
module mode_speed_ctrl
    import mode_speed_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk_50,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_speed,
    output logic [1:0] mode,
    output logic [1:0] sw,
    output logic       mode_chg,
    output logic       speed_chg
);

    logic [NUM_KEYS-1:0] btn_raw;
    logic [NUM_KEYS-1:0] key_db;
    logic [NUM_KEYS-1:0] key_press;

    assign btn_raw[KEY_MODE]  = btn_mode;
    assign btn_raw[KEY_SPEED] = btn_speed;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            btn_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
            ) u_btn_debounce (
                .clk     (clk_50),
                .rst     (rst),
                .btn_raw (btn_raw[gi]),
                .db      (key_db[gi]),
                .press   (key_press[gi])
            );
        end
    endgenerate

    sel_t mode_q, mode_d;
    sel_t sw_q, sw_d;
    logic mode_chg_q, mode_chg_d;
    logic speed_chg_q, speed_chg_d;

`ifdef MODE_SPEED_LONG_PRESS_EN
    localparam int              HOLD_W    = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_fire;
`else
    // Debounced levels only feed the hold counter, which is absent here.
    logic key_db_unused;
    localparam int long_cycles_unused = LONG_CYCLES;
    assign key_db_unused = ^key_db;
`endif

    always_comb begin
        mode_d      = mode_q;
        sw_d        = sw_q;
        mode_chg_d  = 1'b0;
        speed_chg_d = 1'b0;

        if (key_press[KEY_MODE]) begin
            mode_d     = sel_next(mode_q);
            mode_chg_d = 1'b1;
        end
        if (key_press[KEY_SPEED]) begin
            sw_d        = sel_next(sw_q);
            speed_chg_d = 1'b1;
        end

`ifdef MODE_SPEED_LONG_PRESS_EN
        hold_d    = hold_q;
        long_fire = 1'b0;
        if (!key_db[KEY_MODE]) begin
            hold_d = '0;
        end else if (hold_q != HOLD_MAX) begin
            // Saturate at HOLD_MAX so a single hold fires exactly once.
            hold_d    = hold_q + 1'b1;
            long_fire = (hold_q == HOLD_LAST);
        end
        // Placed last so a coincident speed press loses to the clear.
        if (long_fire) begin
            mode_d      = '0;
            sw_d        = '0;
            mode_chg_d  = 1'b1;
            speed_chg_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            mode_q      <= '0;
            sw_q        <= '0;
            mode_chg_q  <= 1'b0;
            speed_chg_q <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            sw_q        <= sw_d;
            mode_chg_q  <= mode_chg_d;
            speed_chg_q <= speed_chg_d;
        end
    end

`ifdef MODE_SPEED_LONG_PRESS_EN
    always_ff @(posedge clk_50) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    assign mode      = mode_q;
    assign sw        = sw_q;
    assign mode_chg  = mode_chg_q;
    assign speed_chg = speed_chg_q;

endmodule

// File: tb/tb_mode_speed_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mode_speed_ctrl
// Directed scenarios (reset, basic press, glitch, wrap, simultaneous press,
// reset mid-debounce, long press) followed by randomized key activity with
// occasional resets. A cycle-level reference model derived from the
// behavioural rules (sample history, "last N synchronized samples all
// disagree with the clean level", modulo-4 selects) is checked every edge.
// ---------------------------------------------------------------------------
module tb_mode_speed_ctrl;

    localparam int DEB     = 4;
    localparam int LONG    = 20;
    localparam bit ACT_LOW = 1'b1;
    localparam int N       = 8000;

    logic       clk_50 = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b1;
    logic       btn_speed = 1'b1;
    logic [1:0] mode, sw;
    logic       mode_chg, speed_chg;

    mode_speed_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LONG),
        .BTN_ACTIVE_LOW  (ACT_LOW)
    ) dut (
        .clk_50    (clk_50),
        .rst       (rst),
        .btn_mode  (btn_mode),
        .btn_speed (btn_speed),
        .mode      (mode),
        .sw        (sw),
        .mode_chg  (mode_chg),
        .speed_chg (speed_chg)
    );

    always #5 clk_50 = ~clk_50;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit rst_hist[N];
    bit raw_hist[2][N];   // 1 = key pressed, as sampled at each edge
    bit seen_hist[2][N];  // synchronized level presented at each edge
    bit m_db[2];
    int m_mode, m_sw, m_held;
    bit m_mchg, m_schg;
    int edge_n = 0;

    function automatic bit is_pressed(input logic lvl);
        return ACT_LOW ? (lvl == 1'b0) : (lvl == 1'b1);
    endfunction

    task automatic model_edge();
        bit raw_now[2];
        bit press[2];
        bit flip;
        bit old_db0;
        int k;
        k = edge_n;
        if (k >= N) begin
            $display("FAIL model_capacity: got %0d expected below %0d", k, N);
            $fatal(1, "model history exhausted");
        end
        raw_now[0] = is_pressed(btn_mode);
        raw_now[1] = is_pressed(btn_speed);
        rst_hist[k] = rst;
        m_mchg = 1'b0;
        m_schg = 1'b0;
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                raw_hist[b][k]  = 1'b0;
                seen_hist[b][k] = 1'b0;
                m_db[b]         = 1'b0;
            end
            m_mode = 0;
            m_sw   = 0;
            m_held = 0;
        end else begin
            old_db0 = m_db[0];
            for (int b = 0; b < 2; b++) begin
                raw_hist[b][k] = raw_now[b];
                // Two-stage synchronizer: the level seen now was sampled two
                // edges ago, unless a reset edge intervened.
                seen_hist[b][k] = (k < 2 || rst_hist[k-1]) ? 1'b0 : raw_hist[b][k-2];
                flip = 1'b1;
                for (int j = k - DEB + 1; j <= k; j++) begin
                    if (j < 0 || rst_hist[j] || seen_hist[b][j] == m_db[b]) flip = 1'b0;
                end
                press[b] = flip && !m_db[b];
                if (flip) m_db[b] = !m_db[b];
            end
            if (press[0]) begin
                m_mode = (m_mode + 1) % 4;
                m_mchg = 1'b1;
            end
            if (press[1]) begin
                m_sw   = (m_sw + 1) % 4;
                m_schg = 1'b1;
            end
`ifdef MODE_SPEED_LONG_PRESS_EN
            if (old_db0) begin
                if (m_held < LONG) begin
                    m_held++;
                    if (m_held == LONG) begin
                        m_mode = 0;
                        m_sw   = 0;
                        m_mchg = 1'b1;
                        m_schg = 1'b1;
                    end
                end
            end else begin
                m_held = 0;
            end
`endif
        end
        edge_n++;
    endtask

    // One clock edge: advance model on the edge, compare 1 ns later.
    task automatic step();
        @(posedge clk_50);
        model_edge();
        #1;
        check_eq("mode", int'(mode), m_mode);
        check_eq("sw", int'(sw), m_sw);
        check_eq("mode_chg", int'(mode_chg), int'(m_mchg));
        check_eq("speed_chg", int'(speed_chg), int'(m_schg));
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn_mode = 1'b1;
        btn_speed = 1'b1;
        steps(2);
        rst = 1'b0;
    endtask

    // Clean press: hold, then release long enough for the release debounce.
    task automatic press_key(input int which);
        if (which == 0) btn_mode = 1'b0; else btn_speed = 1'b0;
        steps(8);
        if (which == 0) btn_mode = 1'b1; else btn_speed = 1'b1;
        steps(8);
    endtask

    int pulses, pulses_s, m_edge, s_edge, lat;
    int rem_m, rem_s;

    initial begin
        // ---- reset state ----
        steps(3);
        check_eq("reset_mode", int'(mode), 0);
        check_eq("reset_sw", int'(sw), 0);
        check_eq("reset_mode_chg", int'(mode_chg), 0);
        check_eq("reset_speed_chg", int'(speed_chg), 0);

        // ---- basic press: key sampled pressed from post-reset edge 1 ----
        rst = 1'b0;
        btn_mode = 1'b0;
        steps(5);
        check_eq("basic_edge5_mode", int'(mode), 0);
        step();
        check_eq("basic_edge6_mode", int'(mode), 1);
        check_eq("basic_edge6_pulse", int'(mode_chg), 1);
        check_eq("basic_sw", int'(sw), 0);
        step();
        check_eq("basic_pulse_width", int'(mode_chg), 0);
        btn_mode = 1'b1;
        steps(10);
        $display("basic press: mode=%0d sw=%0d", mode, sw);

        // ---- glitch: 3-cycle low pulse on speed key ----
        pulses = 0;
        btn_speed = 1'b0;
        for (int i = 0; i < 3; i++) begin step(); pulses += int'(speed_chg); end
        btn_speed = 1'b1;
        for (int i = 0; i < 12; i++) begin step(); pulses += int'(speed_chg); end
        check_eq("glitch3_sw", int'(sw), 0);
        check_eq("glitch3_pulses", pulses, 0);
        $display("glitch: sw=%0d pulses=%0d", sw, pulses);

        // ---- wrap: four presses from reset give 1,2,3,0 ----
        do_reset();
        pulses = 0;
        for (int p = 0; p < 4; p++) begin
            btn_mode = 1'b0;
            for (int i = 0; i < 8; i++) begin
                step();
                if (mode_chg) begin
                    pulses++;
                    check_eq("wrap_value", int'(mode), (p + 1) % 4);
                end
            end
            btn_mode = 1'b1;
            for (int i = 0; i < 8; i++) begin step(); pulses += int'(mode_chg); end
            $display("wrap press %0d: mode=%0d", p, mode);
        end
        check_eq("wrap_pulse_count", pulses, 4);

        // ---- simultaneous press ----
        m_edge = -1;
        s_edge = -2;
        btn_mode = 1'b0;
        btn_speed = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (mode_chg) m_edge = i;
            if (speed_chg) s_edge = i;
        end
        check_eq("simul_same_edge", m_edge, s_edge);
        check_eq("simul_mode", int'(mode), 1);
        check_eq("simul_sw", int'(sw), 1);
        btn_mode = 1'b1;
        btn_speed = 1'b1;
        steps(10);
        $display("simultaneous: mode=%0d sw=%0d edge=%0d", mode, sw, m_edge);

        // ---- reset two cycles into a debounce, key kept held ----
        btn_mode = 1'b0;
        steps(2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("midrst_mode", int'(mode), 0);
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (mode_chg && lat < 0) lat = i;
        end
        check_eq("midrst_latency", lat, 6);
        check_eq("midrst_mode_after", int'(mode), 1);
        btn_mode = 1'b1;
        steps(10);
        $display("reset mid-debounce: press at post-reset edge %0d", lat);

        // ---- long press from mode=2, sw=3 ----
        do_reset();
        press_key(0);
        press_key(0);
        press_key(1);
        press_key(1);
        press_key(1);
        check_eq("long_setup_mode", int'(mode), 2);
        check_eq("long_setup_sw", int'(sw), 3);
        btn_mode = 1'b0;
        steps(40);
`ifdef MODE_SPEED_LONG_PRESS_EN
        check_eq("long_mode", int'(mode), 0);
        check_eq("long_sw", int'(sw), 0);
`else
        check_eq("long_mode", int'(mode), 3);
        check_eq("long_sw", int'(sw), 3);
`endif
        btn_mode = 1'b1;
        steps(10);
        $display("long press: mode=%0d sw=%0d", mode, sw);

        // ---- randomized key activity with occasional resets ----
        rem_m = 1;
        rem_s = 1;
        for (int c = 0; c < 2500; c++) begin
            rem_m--;
            rem_s--;
            if (rem_m <= 0) begin btn_mode = ~btn_mode; rem_m = $urandom_range(1, 30); end
            if (rem_s <= 0) begin btn_speed = ~btn_speed; rem_s = $urandom_range(1, 30); end
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        $display("random phase: mode=%0d sw=%0d", mode, sw);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
